// File: rtl/traffic_pkg.sv
// Shared intersection types: lane geometry and the sequencer state encoding.
package traffic_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  // Encoding 2'd3 is unused; the sequencer treats it as a fault and returns to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GREEN = 2'd1,
    CLEAR = 2'd2
  } state_t;
endpackage

// File: rtl/norm_phase_seq_if.sv
// Handshake bundle between the control unit and the normal-mode phase sequencer.
interface norm_phase_seq_if;
  import traffic_pkg::*;

  logic              norm_op_en;
  logic [NUM_LANES-1:0] lane_req;
  logic              allow_0_norm;
  logic              allow_1_norm;
  logic              allow_2_norm;
  logic              allow_3_norm;
  logic [LANE_W-1:0] cur_lane;
  logic              phase_done;

  // Control-unit side: drives enable and requests, observes grants.
  modport master (
    output norm_op_en, lane_req,
    input  allow_0_norm, allow_1_norm, allow_2_norm, allow_3_norm,
    input  cur_lane, phase_done
  );

  // Sequencer side.
  modport slave (
    input  norm_op_en, lane_req,
    output allow_0_norm, allow_1_norm, allow_2_norm, allow_3_norm,
    output cur_lane, phase_done
  );
endinterface

// File: rtl/norm_phase_seq_rr_arb4.sv
// Combinational 4-way round-robin picker: first requester after 'last', wrapping.
module rr_arb4
  import traffic_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    last,
  output logic [LANE_W-1:0]    grant_idx,
  output logic                 grant_vld
);

  // Scan from the farthest candidate (last itself) down to last+1 so the
  // nearest requester after 'last' is the one left standing.
  always_comb begin
    logic [LANE_W-1:0] cand;
    cand      = '0;
    grant_idx = last;
    grant_vld = 1'b0;
    for (int i = NUM_LANES; i >= 1; i--) begin
      cand = last + LANE_W'(i);
      if (req[cand]) begin
        grant_idx = cand;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/norm_phase_seq.sv
// Normal-mode phase sequencer: round-robin green windows separated by all-red
// clearance, gated by the control unit's enable.
module norm_phase_seq
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES = 16,
  parameter int CLEAR_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  norm_phase_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [LANE_W-1:0]    last_lane, last_nxt;
  logic [LANE_W-1:0]    cur_q, cur_nxt;
  logic [LANE_W-1:0]    pick_idx;
  logic                 pick_vld;
  logic [NUM_LANES-1:0] allow;
  logic                 done;

  // lane_req is only consumed where the FSM below chooses to use pick_*.
  rr_arb4 u_arb (
    .req       (bus.lane_req),
    .last      (last_lane),
    .grant_idx (pick_idx),
    .grant_vld (pick_vld)
  );

  // State register; last_lane resets to 3 so lane 0 wins the first search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_lane <= LANE_W'(NUM_LANES - 1);
      cur_q     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last_lane <= last_nxt;
      cur_q     <= cur_nxt;
    end
  end

  // Next-state: an enable drop overrides everything and leaves last_lane
  // untouched, so an aborted lane is first in line on re-enable.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last_lane;
    cur_nxt   = cur_q;
    if (!bus.norm_op_en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (pick_vld) begin
            state_nxt = GREEN;
            cur_nxt   = pick_idx;
          end
        end
        GREEN: begin
          if (cnt == GREEN_LAST) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
            last_nxt  = cur_q;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        CLEAR: begin
          if (cnt == CLEAR_LAST) begin
            cnt_nxt = '0;
            if (pick_vld) begin
              state_nxt = GREEN;
              cur_nxt   = pick_idx;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Moore outputs decoded from registers only.
  always_comb begin
    allow = '0;
    for (int n = 0; n < NUM_LANES; n++)
      allow[n] = (state == GREEN) && (cur_q == LANE_W'(n));
    done = (state == GREEN) && (cnt == GREEN_LAST);
  end

  assign bus.allow_0_norm = allow[0];
  assign bus.allow_1_norm = allow[1];
  assign bus.allow_2_norm = allow[2];
  assign bus.allow_3_norm = allow[3];
  assign bus.cur_lane     = cur_q;
  assign bus.phase_done   = done;

endmodule
